// File: rtl/emu_time_pkg.sv
// Shared definitions for the emulation time manager: FSM state encoding,
// default absolute-time width and the global timestep width.
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif

package emu_time_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } emu_state_e;

  localparam int unsigned DEFAULT_TIME_WIDTH = 64;

endpackage

// File: rtl/dt_min_tree.sv
// Combinational unsigned minimum over N_REQ flattened timestep requests.
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif

module dt_min_tree #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = `DT_WIDTH
) (
  input  logic [N_REQ*WIDTH-1:0] i_dt,
  output logic [WIDTH-1:0]       o_min
);

  // Linear scan; slot 0 seeds the running minimum.
  always_comb begin
    o_min = i_dt[WIDTH-1:0];
    for (int unsigned i = 1; i < N_REQ; i++) begin
      if (i_dt[i*WIDTH +: WIDTH] < o_min) begin
        o_min = i_dt[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/emu_time_manager.sv
// Emulation time manager: grants the smallest requested timestep each cycle,
// clamps it to an optional stop-time breakpoint, and sequences
// pause / free-run / single-step / halt operation.
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif

module emu_time_manager
  import emu_time_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned TIME_WIDTH = DEFAULT_TIME_WIDTH
) (
  input  logic                         __emu_clk,
  input  logic                         __emu_rst,
  input  logic [N_REQ*`DT_WIDTH-1:0]   dt_req,
  input  logic                         ctrl_run,
  input  logic                         ctrl_step,
  input  logic                         stop_en,
  input  logic [TIME_WIDTH-1:0]        stop_time,
  output logic [`DT_WIDTH-1:0]         __emu_dt,
  output logic [TIME_WIDTH-1:0]        emu_time,
  output logic [31:0]                  step_count,
  output logic [1:0]                   state,
  output logic                         halted
);

  logic [`DT_WIDTH-1:0]  w_dt_min;
  logic [TIME_WIDTH-1:0] w_remain;
  logic                  w_clamp_hit;
  logic                  w_at_stop;
  logic                  w_step_edge;
  logic                  w_granting;

  emu_state_e            r_state;
  logic                  r_halted;
  logic [TIME_WIDTH-1:0] r_emu_time;
  logic [31:0]           r_step_count;
  logic                  r_step_prev;

  dt_min_tree #(
    .N_REQ (N_REQ),
    .WIDTH (`DT_WIDTH)
  ) u_dt_min (
    .i_dt  (dt_req),
    .o_min (w_dt_min)
  );

  // Distance to the breakpoint wraps at TIME_WIDTH; the clamp compares the
  // zero-extended minimum against it at full width.
  assign w_remain    = stop_time - r_emu_time;
  assign w_clamp_hit = stop_en && (w_remain < TIME_WIDTH'(w_dt_min));
  assign w_at_stop   = stop_en && (w_remain == '0);
  assign w_step_edge = ctrl_step && !r_step_prev;
  assign w_granting  = !__emu_rst && ((r_state == RUN) || (r_state == STEP));

  // Same-cycle grant: clamped remainder near the breakpoint, else the minimum.
  always_comb begin
    __emu_dt = '0;
    if (w_granting) begin
      __emu_dt = w_clamp_hit ? w_remain[`DT_WIDTH-1:0] : w_dt_min;
    end
  end

  // Run-control FSM; stop has priority over run, run over step.
  always_ff @(posedge __emu_clk) begin
    if (__emu_rst) begin
      r_state  <= PAUSE;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        PAUSE: begin
          if (w_at_stop) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (ctrl_run) begin
            r_state <= RUN;
          end else if (w_step_edge) begin
            r_state <= STEP;
          end
        end
        RUN: begin
          if (w_clamp_hit || w_at_stop) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (!ctrl_run) begin
            r_state <= PAUSE;
          end
        end
        STEP: begin
          if (w_clamp_hit) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= PAUSE;
          end
        end
        HALT: begin
          if (!w_at_stop) begin
            r_state  <= PAUSE;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= PAUSE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Time accumulation, saturating step counter and step-request edge history.
  always_ff @(posedge __emu_clk) begin
    if (__emu_rst) begin
      r_emu_time   <= '0;
      r_step_count <= '0;
      r_step_prev  <= 1'b0;
    end else begin
      r_emu_time  <= r_emu_time + TIME_WIDTH'(__emu_dt);
      r_step_prev <= ctrl_step;
      if ((__emu_dt != '0) && (r_step_count != '1)) begin
        r_step_count <= r_step_count + 32'd1;
      end
    end
  end

  assign emu_time   = r_emu_time;
  assign step_count = r_step_count;
  assign state      = r_state;
  assign halted     = r_halted;

endmodule
